// File: rtl/xor_parity_arbiter_v.sv
// -----------------------------------------------------------------------------
// xor_parity_arbiter_v
//   Two-requester bit-serial parity engine. Requesters share one XOR2_gate_v
//   instance under round-robin arbitration. An accepted WIDTH-bit word is
//   shifted through the gate one bit per cycle. The parity and the requester
//   ID are then offered on a valid/ready output handshake.
//
// Parameters
//   WIDTH  data word width, 2..32
//   ODD    0 = even parity (XOR of all bits), 1 = odd parity (inverted)
//
// Ports
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_reqN_valid / i_reqN_data          requester N word offer (N = 0, 1)
//   o_reqN_ready                        requester N word taken this cycle
//   o_out_valid / o_out_parity/o_out_id result handshake toward consumer
//   i_out_ready                         consumer takes the result
//   o_busy                              engine in SHIFT or DONE
// -----------------------------------------------------------------------------

// Shared 2-input XOR: the only XOR in the engine.
module XOR2_gate_v (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module xor_parity_arbiter_v #(
    parameter int WIDTH = 8,
    parameter bit ODD   = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    input  logic [WIDTH-1:0] i_req0_data,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [WIDTH-1:0] i_req1_data,
    output logic             o_req1_ready,
    output logic             o_out_valid,
    output logic             o_out_parity,
    output logic             o_out_id,
    input  logic             i_out_ready,
    output logic             o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic             acc;
    logic             acc_nxt;
    logic [4:0]       cnt;
    logic             res;
    logic             id;
    logic             ptr;
    logic             out_valid;
    logic             busy;
    logic             gnt_vld;
    logic             gnt_id;
    logic             accept;
    logic             last_bit;

    XOR2_gate_v u_xor (
        .a (acc),
        .b (shreg[0]),
        .y (acc_nxt)
    );

    // Round-robin: the pointer only breaks ties.
    always_comb begin
        gnt_vld = i_req0_valid | i_req1_valid;
        gnt_id  = (i_req0_valid & i_req1_valid) ? ptr : i_req1_valid;
    end

    assign o_req0_ready = (state == S_IDLE) && gnt_vld && !gnt_id && i_req0_valid;
    assign o_req1_ready = (state == S_IDLE) && gnt_vld &&  gnt_id && i_req1_valid;
    assign accept       = o_req0_ready | o_req1_ready;
    assign last_bit     = (cnt == 5'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)                   state_nxt = S_SHIFT;
            S_SHIFT: if (last_bit)                 state_nxt = S_DONE;
            S_DONE:  if (out_valid && i_out_ready) state_nxt = S_IDLE;
            default:                               state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            shreg     <= '0;
            acc       <= 1'b0;
            cnt       <= '0;
            res       <= 1'b0;
            id        <= 1'b0;
            ptr       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shreg <= gnt_id ? i_req1_data : i_req0_data;
                        acc   <= 1'b0;
                        cnt   <= '0;
                        id    <= gnt_id;
                        ptr   <= ~gnt_id;
                    end
                end
                S_SHIFT: begin
                    acc   <= acc_nxt;
                    shreg <= shreg >> 1;
                    cnt   <= cnt + 5'd1;
                end
                S_DONE: begin
                    // First DONE cycle latches the result, so valid rises one
                    // edge after the last shift; then hold until consumed.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        res       <= ODD ? ~acc : acc;
                    end else if (i_out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_out_valid  = out_valid;
    assign o_out_parity = res;
    assign o_out_id     = id;
    assign o_busy       = busy;

endmodule

// File: tb/tb_xor_parity_arbiter_v.sv
module tb_xor_parity_arbiter_v;

    localparam int WIDTH = 8;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_req0_valid = 1'b0, i_req1_valid = 1'b0;
    logic [WIDTH-1:0] i_req0_data = '0, i_req1_data = '0;
    logic             o_req0_ready, o_req1_ready;
    logic             o_out_valid, o_out_parity, o_out_id, o_busy;
    logic             i_out_ready = 1'b1;

    // odd-parity instance, requester 0 only
    logic             od_req0_valid = 1'b0;
    logic [WIDTH-1:0] od_req0_data = '0;
    logic             od_req1_valid = 1'b0;
    logic [WIDTH-1:0] od_req1_data = '0;
    logic             od_req0_ready, od_req1_ready;
    logic             od_out_valid, od_out_parity, od_out_id, od_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    xor_parity_arbiter_v #(.WIDTH(WIDTH), .ODD(1'b0)) u_dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req0_valid (i_req0_valid),
        .i_req0_data  (i_req0_data),
        .o_req0_ready (o_req0_ready),
        .i_req1_valid (i_req1_valid),
        .i_req1_data  (i_req1_data),
        .o_req1_ready (o_req1_ready),
        .o_out_valid  (o_out_valid),
        .o_out_parity (o_out_parity),
        .o_out_id     (o_out_id),
        .i_out_ready  (i_out_ready),
        .o_busy       (o_busy)
    );

    xor_parity_arbiter_v #(.WIDTH(WIDTH), .ODD(1'b1)) u_odd (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req0_valid (od_req0_valid),
        .i_req0_data  (od_req0_data),
        .o_req0_ready (od_req0_ready),
        .i_req1_valid (od_req1_valid),
        .i_req1_data  (od_req1_data),
        .o_req1_ready (od_req1_ready),
        .o_out_valid  (od_out_valid),
        .o_out_parity (od_out_parity),
        .o_out_id     (od_out_id),
        .i_out_ready  (1'b1),
        .o_busy       (od_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // leave at 1 time unit after a rising edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    // returns number of edges waited until o_out_valid, bounded
    task automatic wait_out(input int max_cyc, output int lat);
        lat = 0;
        while (!o_out_valid && lat < max_cyc) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;

        // reset state, asynchronous
        #2;
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_parity", o_out_parity, 0);
        chk("rst_id", o_out_id, 0);
        do_reset();

        // 1: idle with no requests
        for (int i = 0; i < 4; i++) begin
            chk("idle_rdy0", o_req0_ready, 0);
            chk("idle_rdy1", o_req1_ready, 0);
            chk("idle_valid", o_out_valid, 0);
            chk("idle_busy", o_busy, 0);
            tick();
        end

        // 2: single word 0xB5 on req0, latency WIDTH+1
        i_req0_data = 8'hB5; i_req0_valid = 1'b1; i_out_ready = 1'b1;
        #1;
        chk("t2_rdy0", o_req0_ready, 1);
        chk("t2_rdy1", o_req1_ready, 0);
        tick();                                   // edge T
        i_req0_valid = 1'b0;
        chk("t2_busy_T", o_busy, 1);
        for (int k = 1; k <= WIDTH; k++) begin
            tick();
            chk("t2_no_valid_early", o_out_valid, 0);
        end
        tick();                                   // edge T+9
        chk("t2_valid", o_out_valid, 1);
        chk("t2_parity", o_out_parity, 1);
        chk("t2_id", o_out_id, 0);
        tick();
        chk("t2_valid_drop", o_out_valid, 0);
        chk("t2_busy_drop", o_busy, 0);

        // 3: both held valid from reset -> strict alternation
        do_reset();
        i_req0_data = 8'h03; i_req1_data = 8'h07;
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        #1;
        chk("t3_tie_rdy0", o_req0_ready, 1);
        chk("t3_tie_rdy1", o_req1_ready, 0);
        for (int i = 0; i < 4; i++) begin
            wait_out(30, lat);
            chk("t3_got_result", o_out_valid, 1);
            chk("t3_id", o_out_id, i % 2);
            chk("t3_parity", o_out_parity, i % 2);
            tick();
        end
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;

        // 4: back-pressure on 0xFF from req1, req0 waiting
        do_reset();
        i_req1_data = 8'hFF; i_req1_valid = 1'b1; i_out_ready = 1'b0;
        #1;
        chk("t4_rdy1", o_req1_ready, 1);
        tick();
        i_req1_valid = 1'b0;
        wait_out(30, lat);
        chk("t4_got_result", o_out_valid, 1);
        i_req0_data = 8'h01; i_req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_hold_valid", o_out_valid, 1);
            chk("t4_hold_parity", o_out_parity, 0);
            chk("t4_hold_id", o_out_id, 1);
            chk("t4_hold_rdy0", o_req0_ready, 0);
            chk("t4_hold_rdy1", o_req1_ready, 0);
            tick();
        end
        i_out_ready = 1'b1;
        tick();                                   // consume edge
        chk("t4_consumed", o_out_valid, 0);
        chk("t4_rdy0_next", o_req0_ready, 1);
        tick();                                   // req0 accepted
        i_req0_data = 8'hFE;                      // must be ignored
        i_req0_valid = 1'b0;
        chk("t4_busy_after_acc", o_busy, 1);
        wait_out(30, lat);
        chk("t4_second_valid", o_out_valid, 1);
        chk("t4_second_parity", o_out_parity, 1);
        chk("t4_second_id", o_out_id, 0);
        tick();

        // 5: async reset mid-shift
        do_reset();
        i_req1_data = 8'h55; i_req1_valid = 1'b1;  // move pointer to 0->1 path
        tick();
        i_req1_valid = 1'b0;
        tick(); tick(); tick();                    // 3 bits shifted
        chk("t5_busy_pre", o_busy, 1);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("t5_busy_async", o_busy, 0);
        chk("t5_valid_async", o_out_valid, 0);
        #1;
        i_rst_n = 1'b1;
        for (int i = 0; i < WIDTH + 3; i++) begin
            tick();
            chk("t5_no_result", o_out_valid, 0);
        end
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        #1;
        chk("t5_tie_rdy0", o_req0_ready, 1);
        chk("t5_tie_rdy1", o_req1_ready, 0);
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;

        // 6: odd parity instance
        do_reset();
        od_req0_data = 8'h00; od_req0_valid = 1'b1;
        #1;
        chk("t6_rdy", od_req0_ready, 1);
        tick();
        od_req0_valid = 1'b0;
        lat = 0;
        while (!od_out_valid && lat < 30) begin tick(); lat++; end
        chk("t6a_latency", lat, WIDTH + 1);
        chk("t6a_parity", od_out_parity, 1);
        tick();
        od_req0_data = 8'h01; od_req0_valid = 1'b1;
        tick();
        od_req0_valid = 1'b0;
        lat = 0;
        while (!od_out_valid && lat < 30) begin tick(); lat++; end
        chk("t6b_latency", lat, WIDTH + 1);
        chk("t6b_parity", od_out_parity, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
